// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: accepts a WIDTH-bit word on a
// valid/ready handshake and drives it LSB-first, one bit per clock.
// A word offered during the last bit of the current word is taken at once,
// which allows back-to-back words with no idle cycle between them.
module piso_serializer #(
    parameter int unsigned WIDTH      = 4,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Ready while idle or while the last bit of a word is on the line.
    assign load_ready = (state_q == IDLE) || (cnt_q == LAST);

    // Next-state and next-output decode; outputs follow the next state so
    // they are registered and never depend on din or load_valid directly.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load_valid && load_ready) begin
            state_d = SHIFT;
            shreg_d = din;
            cnt_d   = '0;
        end else if (state_q == SHIFT) begin
            if (cnt_q == LAST) begin
                state_d = IDLE;
            end else begin
                shreg_d = shreg_q >> 1;
                cnt_d   = cnt_q + CW'(1);
            end
        end
        sout_d       = (state_d == SHIFT) ? shreg_d[0] : IDLE_LEVEL;
        sout_valid_d = (state_d == SHIFT);
        busy_d       = (state_d == SHIFT);
        done_d       = (state_d == SHIFT) && (cnt_d == LAST);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            sout_q       <= IDLE_LEVEL;
            sout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: WIDTH=4 and WIDTH=8 instances share stimulus;
// a bit-index model plus a loopback receiver is checked every cycle, and
// directed sequences pin the model with literal expectations.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic [7:0] din;

    logic ready4, sout4, valid4, busy4, done4;
    logic ready8, sout8, valid8, busy8, done8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .IDLE_LEVEL(1'b0)) u_w4 (
        .clk(clk), .rst(rst), .din(din[3:0]), .load_valid(load_valid),
        .load_ready(ready4), .sout(sout4), .sout_valid(valid4),
        .busy(busy4), .done(done4)
    );

    piso_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b0)) u_w8 (
        .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
        .load_ready(ready8), .sout(sout8), .sout_valid(valid8),
        .busy(busy8), .done(done8)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: word being sent and index of the bit on the line (-1 = idle).
    int         pos[2] = '{-1, -1};
    logic [7:0] word[2];
    bit         model_en = 1'b0;
    logic [3:0] lb4 = '0;
    logic [7:0] lb8 = '0;

    function automatic int wd(input int i);
        return (i == 0) ? 4 : 8;
    endfunction

    // Advance the model on each clock edge from the bench's own inputs.
    always @(posedge clk) begin
        if (rst) begin
            model_en = 1'b1;
            pos[0] = -1;
            pos[1] = -1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if ((pos[i] < 0 || pos[i] == wd(i) - 1) && load_valid) begin
                    word[i] = (i == 0) ? {4'b0, din[3:0]} : din;
                    pos[i]  = 0;
                end else if (pos[i] >= 0 && pos[i] < wd(i) - 1) begin
                    pos[i]++;
                end else begin
                    pos[i] = -1;
                end
            end
        end
    end

    // Compare both instances against the model every cycle; feed loopback.
    always @(negedge clk) begin
        if (model_en) begin
            for (int i = 0; i < 2; i++) begin
                logic a_s, a_v, a_b, a_d, a_r;
                logic e_s, e_v, e_d, e_r;
                string tag;
                tag = (i == 0) ? "w4" : "w8";
                a_s = (i == 0) ? sout4  : sout8;
                a_v = (i == 0) ? valid4 : valid8;
                a_b = (i == 0) ? busy4  : busy8;
                a_d = (i == 0) ? done4  : done8;
                a_r = (i == 0) ? ready4 : ready8;
                e_v = (pos[i] >= 0);
                e_s = e_v ? word[i][pos[i]] : 1'b0;
                e_d = (pos[i] == wd(i) - 1);
                e_r = (pos[i] < 0) || e_d;
                chk({tag, " sout"},       32'(a_s), 32'(e_s));
                chk({tag, " sout_valid"}, 32'(a_v), 32'(e_v));
                chk({tag, " busy"},       32'(a_b), 32'(e_v));
                chk({tag, " done"},       32'(a_d), 32'(e_d));
                chk({tag, " load_ready"}, 32'(a_r), 32'(e_r));
                if (a_v) begin
                    if (i == 0) lb4 = {a_s, lb4[3:1]};
                    else        lb8 = {a_s, lb8[7:1]};
                end
                if (e_d) begin
                    if (i == 0) chk("w4 loopback", 32'(lb4), 32'(word[0][3:0]));
                    else        chk("w8 loopback", 32'(lb8), 32'(word[1]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Literal check of one WIDTH=4 cycle, then advance to the next cycle.
    task automatic cyc4(input string nm, input logic s, input logic v,
                        input logic d, input logic r);
        #2;
        chk({nm, " sout"},  32'(sout4),  32'(s));
        chk({nm, " valid"}, 32'(valid4), 32'(v));
        chk({nm, " busy"},  32'(busy4),  32'(v));
        chk({nm, " done"},  32'(done4),  32'(d));
        chk({nm, " ready"}, 32'(ready4), 32'(r));
        tick();
    endtask

    task automatic cyc8(input string nm, input logic s, input logic v, input logic d);
        #2;
        chk({nm, " sout"},  32'(sout8),  32'(s));
        chk({nm, " valid"}, 32'(valid8), 32'(v));
        chk({nm, " done"},  32'(done8),  32'(d));
        tick();
    endtask

    initial begin
        logic [7:0] c5_bits;
        // Reset held two cycles with a word offered: nothing accepted.
        rst = 1'b1; load_valid = 1'b1; din = 8'hFF;
        tick();
        cyc4("rst c1", 0, 0, 0, 1);
        rst = 1'b0; load_valid = 1'b0;
        cyc4("rst rel", 0, 0, 0, 1);
        cyc4("rst idle", 0, 0, 0, 1);

        // Single word 1011 -> 1,1,0,1.
        din = 8'h0B; load_valid = 1'b1;
        cyc4("single acc", 0, 0, 0, 1);
        load_valid = 1'b0;
        cyc4("single b0", 1, 1, 0, 0);
        cyc4("single b1", 1, 1, 0, 0);
        cyc4("single b2", 0, 1, 0, 0);
        cyc4("single b3", 1, 1, 1, 1);
        cyc4("single idle", 0, 0, 0, 1);
        chk("single lb4 literal", 32'(lb4), 32'h0B);

        // Back-to-back A then 5 -> 0,1,0,1,1,0,1,0 with no gap.
        din = 8'h0A; load_valid = 1'b1;
        cyc4("b2b acc", 0, 0, 0, 1);
        din = 8'h05;
        cyc4("b2b a0", 0, 1, 0, 0);
        cyc4("b2b a1", 1, 1, 0, 0);
        cyc4("b2b a2", 0, 1, 0, 0);
        cyc4("b2b a3", 1, 1, 1, 1);
        load_valid = 1'b0;
        cyc4("b2b b0", 1, 1, 0, 0);
        cyc4("b2b b1", 0, 1, 0, 0);
        cyc4("b2b b2", 1, 1, 0, 0);
        cyc4("b2b b3", 0, 1, 1, 1);
        cyc4("b2b idle", 0, 0, 0, 1);

        // Offer C while 3 is shifting; taken only at the last-bit edge.
        din = 8'h03; load_valid = 1'b1;
        cyc4("ign acc", 0, 0, 0, 1);
        load_valid = 1'b0;
        cyc4("ign b0", 1, 1, 0, 0);
        din = 8'h0C; load_valid = 1'b1;
        cyc4("ign b1", 1, 1, 0, 0);
        cyc4("ign b2", 0, 1, 0, 0);
        cyc4("ign b3", 0, 1, 1, 1);
        load_valid = 1'b0;
        cyc4("ign c0", 0, 1, 0, 0);
        cyc4("ign c1", 0, 1, 0, 0);
        cyc4("ign c2", 1, 1, 0, 0);
        cyc4("ign c3", 1, 1, 1, 1);
        cyc4("ign idle", 0, 0, 0, 1);

        // Reset during bit 2 of 9, then 6 -> 0,1,1,0.
        din = 8'h09; load_valid = 1'b1;
        cyc4("mid acc", 0, 0, 0, 1);
        load_valid = 1'b0;
        cyc4("mid b0", 1, 1, 0, 0);
        cyc4("mid b1", 0, 1, 0, 0);
        rst = 1'b1;
        cyc4("mid b2", 0, 1, 0, 0);
        rst = 1'b0;
        cyc4("mid after", 0, 0, 0, 1);
        din = 8'h06; load_valid = 1'b1;
        cyc4("mid6 acc", 0, 0, 0, 1);
        load_valid = 1'b0;
        cyc4("mid6 b0", 0, 1, 0, 0);
        cyc4("mid6 b1", 1, 1, 0, 0);
        cyc4("mid6 b2", 1, 1, 0, 0);
        cyc4("mid6 b3", 0, 1, 1, 1);

        // WIDTH=8 word C5 -> 1,0,1,0,0,0,1,1.
        repeat (10) tick();
        din = 8'hC5; load_valid = 1'b1;
        cyc8("w8 acc", 0, 0, 0);
        load_valid = 1'b0;
        c5_bits = 8'hC5;
        for (int k = 0; k < 8; k++) begin
            cyc8($sformatf("w8 b%0d", k), c5_bits[k], 1'b1, (k == 7) ? 1'b1 : 1'b0);
        end
        cyc8("w8 idle", 0, 0, 0);
        chk("w8 lb8 literal", 32'(lb8), 32'hC5);

        // Randomized traffic with occasional resets.
        repeat (3000) begin
            rst        = ($urandom_range(0, 99) == 0);
            load_valid = ($urandom_range(0, 3) != 0);
            din        = 8'($urandom);
            tick();
        end
        rst = 1'b0; load_valid = 1'b0;
        repeat (12) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
